sbox_sched: RTL

Time-multiplexing controller for the shared byte-substitution S-box bank. It accepts a 128-bit state plus direction over a valid/ready handshake and issues its 16 bytes to a narrow S-box bank, LANES bytes per cycle. It collects the registered S-box outputs and presents the substituted 128-bit state over a second valid/ready handshake. It sits between the round controller and a LANES-wide S-box bank, so SubBytes and InvSubBytes use LANES S-box instances instead of 16.

---
 rtl/sbox_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sbox_sched.sv
// Time-multiplexes a 16-byte state through a LANES-wide S-box bank (N = 16/LANES issue cycles).
// Optional abort input enabled by defining SBOX_SCHED_ABORT_EN.
module sbox_sched #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         state_in,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         state_out,
    output logic                 busy,
    output logic [8*LANES-1:0]   sbox_addr,
    output logic                 sbox_sel,
    input  logic [8*LANES-1:0]   sbox_data
`ifdef SBOX_SCHED_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    localparam int N  = 16 / LANES;
    localparam int W  = 8 * LANES;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam int            LAST_SH = (N - 1) * W;
    localparam logic [127:0]  LMASK   = 128'((129'd1 << W) - 129'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [KW-1:0]  k_prev;
    logic [KW-1:0]  addr_grp;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   acc_q, acc_d;
    logic [127:0]   out_q, out_d;
    logic           mode_q, mode_d;
    logic           abort_w;
    int             cap_sh;

`ifdef SBOX_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Bank output lags the address by one clock, so ISSUE cycle k captures group k-1.
    assign k_prev = k_q - KW'(1);
    assign cap_sh = int'(k_prev) * W;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        blk_d   = blk_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    blk_d   = state_in;
                    mode_d  = in_mode;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (k_q != '0) begin
                    acc_d = (acc_q & ~(LMASK << cap_sh)) | (128'(sbox_data) << cap_sh);
                end
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                out_d   = (acc_q & ~(LMASK << LAST_SH)) | (128'(sbox_data) << LAST_SH);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_w && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            blk_q  <= '0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            out_q  <= '0;
        end else begin
            k_q    <= k_d;
            blk_q  <= blk_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
        end
    end

    assign addr_grp  = (state_q == S_ISSUE) ? k_q : '0;
    assign sbox_addr = W'(blk_q >> (int'(addr_grp) * W));
    assign sbox_sel  = mode_q;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign state_out = out_q;

endmodule
